// File: rtl/pec_row_seq.sv
// Row sequencer: loads one weight packet, then runs LENPSUM activation columns through the MAC chain.
// Define PEC_ROW_WDOG_EN to add a WAIT-state watchdog that raises the sticky seq_err output.
module pec_row_seq #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_DEPTH = 32,
    parameter int BLOCK_DEPTH   = 32,
    parameter int KERNEL_SIZE   = 9,
    parameter int LENPSUM       = 14,
    parameter int TIMEOUT       = 1024,
    localparam int AW           = $clog2(BLOCK_DEPTH * KERNEL_SIZE)
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         row_sta,
    output logic                                         row_busy,
    output logic                                         row_fnh,
    input  logic                                         wei_vld,
    output logic                                         wei_rdy,
    input  logic [CHANNEL_DEPTH-1:0]                     wei_flg0,
    input  logic [CHANNEL_DEPTH-1:0]                     wei_flg1,
    input  logic [CHANNEL_DEPTH-1:0]                     wei_flg2,
    input  logic [DATA_WIDTH*BLOCK_DEPTH*KERNEL_SIZE-1:0] wei_dat,
    input  logic                                         act_vld,
    output logic                                         act_rdy,
    input  logic [CHANNEL_DEPTH-1:0]                     act_flg,
    input  logic [DATA_WIDTH*CHANNEL_DEPTH-1:0]          act_dat,
    output logic                                         PECMAC_Sta,
    input  logic                                         MACPEC_Fnh0,
    input  logic                                         MACPEC_Fnh1,
    input  logic                                         MACPEC_Fnh2,
    output logic [CHANNEL_DEPTH-1:0]                     PECMAC_FlgAct,
    output logic [DATA_WIDTH*CHANNEL_DEPTH-1:0]          PECMAC_Act,
    output logic [CHANNEL_DEPTH-1:0]                     PECMAC_FlgWei0,
    output logic [CHANNEL_DEPTH-1:0]                     PECMAC_FlgWei1,
    output logic [CHANNEL_DEPTH-1:0]                     PECMAC_FlgWei2,
    output logic [DATA_WIDTH*BLOCK_DEPTH*KERNEL_SIZE-1:0] PECMAC_Wei,
    output logic [AW-1:0]                                PECMAC_AddrBaseWei0,
    output logic [AW-1:0]                                PECMAC_AddrBaseWei1,
    output logic [AW-1:0]                                PECMAC_AddrBaseWei2,
    output logic                                         PECCNV_PlsAcc,
    output logic                                         PECCNV_FnhRow,
    output logic                                         seq_err
);

    localparam int WEI_W = DATA_WIDTH * BLOCK_DEPTH * KERNEL_SIZE;
    localparam int ACT_W = DATA_WIDTH * CHANNEL_DEPTH;
    localparam int CW    = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LENPSUM - 1);

    generate
        if (LENPSUM < 1 || TIMEOUT < 1 || 2 * CHANNEL_DEPTH >= BLOCK_DEPTH * KERNEL_SIZE) begin : g_bad_params
            $error("pec_row_seq: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        ALOAD,
        START,
        WAIT,
        ACC,
        ROWEND
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]            col_cnt_q;
    logic [2:0]               fnh_q;
    logic [2:0]               fnh_now;
    logic                     all_fnh;
    logic                     wdog_exp;
    logic [CHANNEL_DEPTH-1:0] act_flg_q;
    logic [ACT_W-1:0]         act_dat_q;
    logic [CHANNEL_DEPTH-1:0] wei_flg0_q;
    logic [CHANNEL_DEPTH-1:0] wei_flg1_q;
    logic [CHANNEL_DEPTH-1:0] wei_flg2_q;
    logic [WEI_W-1:0]         wei_dat_q;
    logic [AW-1:0]            base1_q;
    logic [AW-1:0]            base2_q;
    logic [AW-1:0]            pop0;
    logic [AW-1:0]            pop1;

    function automatic logic [AW-1:0] popcnt(input logic [CHANNEL_DEPTH-1:0] v);
        logic [AW-1:0] c;
        c = '0;
        for (int i = 0; i < CHANNEL_DEPTH; i++) begin
            c = c + AW'(v[i]);
        end
        return c;
    endfunction

    assign pop0    = popcnt(wei_flg0);
    assign pop1    = popcnt(wei_flg1);
    assign fnh_now = {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0};
    // A finish arriving in the same cycle as the last missing sticky bit still counts.
    assign all_fnh = &(fnh_q | fnh_now);

`ifdef PEC_ROW_WDOG_EN
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wdog_q;
    logic          err_q;

    assign wdog_exp = (state_q == WAIT) && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == START) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_exp && !all_fnh) begin
                err_q <= 1'b1;
            end
        end
    end

    assign seq_err = err_q;
`else
    assign wdog_exp = 1'b0;
    assign seq_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (row_sta) state_d = WLOAD;
            WLOAD:   if (wei_vld) state_d = ALOAD;
            ALOAD:   if (act_vld) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (all_fnh || wdog_exp) state_d = ACC;
            ACC:     state_d = (col_cnt_q == COL_LAST) ? ROWEND : ALOAD;
            ROWEND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_busy      = (state_q != IDLE);
        wei_rdy       = 1'b0;
        act_rdy       = 1'b0;
        PECMAC_Sta    = 1'b0;
        PECCNV_PlsAcc = 1'b0;
        PECCNV_FnhRow = 1'b0;
        row_fnh       = 1'b0;
        case (state_q)
            WLOAD:  wei_rdy       = 1'b1;
            ALOAD:  act_rdy       = 1'b1;
            START:  PECMAC_Sta    = 1'b1;
            ACC:    PECCNV_PlsAcc = 1'b1;
            ROWEND: begin
                PECCNV_FnhRow = 1'b1;
                row_fnh       = 1'b1;
            end
            default: ;
        endcase
    end

    // Weights are written only in WLOAD and activations only in ALOAD, so both hold between accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wei_flg0_q <= '0;
            wei_flg1_q <= '0;
            wei_flg2_q <= '0;
            wei_dat_q  <= '0;
            base1_q    <= '0;
            base2_q    <= '0;
            act_flg_q  <= '0;
            act_dat_q  <= '0;
            fnh_q      <= '0;
            col_cnt_q  <= '0;
        end else begin
            if (state_q == WLOAD && wei_vld) begin
                wei_flg0_q <= wei_flg0;
                wei_flg1_q <= wei_flg1;
                wei_flg2_q <= wei_flg2;
                wei_dat_q  <= wei_dat;
                base1_q    <= pop0;
                base2_q    <= pop0 + pop1;
            end
            if (state_q == ALOAD && act_vld) begin
                act_flg_q <= act_flg;
                act_dat_q <= act_dat;
            end
            if (state_q == START) begin
                fnh_q <= '0;
            end else if (state_q == WAIT) begin
                fnh_q <= fnh_q | fnh_now;
            end
            if (state_q == ACC) begin
                col_cnt_q <= (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + 1'b1;
            end
        end
    end

    assign PECMAC_FlgAct       = act_flg_q;
    assign PECMAC_Act          = act_dat_q;
    assign PECMAC_FlgWei0      = wei_flg0_q;
    assign PECMAC_FlgWei1      = wei_flg1_q;
    assign PECMAC_FlgWei2      = wei_flg2_q;
    assign PECMAC_Wei          = wei_dat_q;
    assign PECMAC_AddrBaseWei0 = '0;
    assign PECMAC_AddrBaseWei1 = base1_q;
    assign PECMAC_AddrBaseWei2 = base2_q;

endmodule

// File: tb/tb_pec_row_seq.sv
// Scoreboard bench for pec_row_seq: stimulus tasks queue expected Sta/PlsAcc/FnhRow events with
// their cycle stamps, and a negedge monitor pops and compares them as the DUT emits strobes.
module tb_pec_row_seq;

    localparam int DW    = 8;
    localparam int CD    = 32;
    localparam int BD    = 32;
    localparam int KS    = 9;
    localparam int LP    = 4;
    localparam int TO    = 16;
    localparam int AW    = $clog2(BD * KS);
    localparam int WEI_W = DW * BD * KS;
    localparam int ACT_W = DW * CD;

    localparam int KIND_STA = 0;
    localparam int KIND_ACC = 1;
    localparam int KIND_ROW = 2;

    typedef struct {
        int               kind;
        int               cyc;
        logic [ACT_W-1:0] act;
        logic [CD-1:0]    flg;
    } expT;

    logic              clk;
    logic              rst_n;
    logic              row_sta;
    logic              row_busy;
    logic              row_fnh;
    logic              wei_vld;
    logic              wei_rdy;
    logic [CD-1:0]     wei_flg0;
    logic [CD-1:0]     wei_flg1;
    logic [CD-1:0]     wei_flg2;
    logic [WEI_W-1:0]  wei_dat;
    logic              act_vld;
    logic              act_rdy;
    logic [CD-1:0]     act_flg;
    logic [ACT_W-1:0]  act_dat;
    logic              PECMAC_Sta;
    logic              MACPEC_Fnh0;
    logic              MACPEC_Fnh1;
    logic              MACPEC_Fnh2;
    logic [CD-1:0]     PECMAC_FlgAct;
    logic [ACT_W-1:0]  PECMAC_Act;
    logic [CD-1:0]     PECMAC_FlgWei0;
    logic [CD-1:0]     PECMAC_FlgWei1;
    logic [CD-1:0]     PECMAC_FlgWei2;
    logic [WEI_W-1:0]  PECMAC_Wei;
    logic [AW-1:0]     PECMAC_AddrBaseWei0;
    logic [AW-1:0]     PECMAC_AddrBaseWei1;
    logic [AW-1:0]     PECMAC_AddrBaseWei2;
    logic              PECCNV_PlsAcc;
    logic              PECCNV_FnhRow;
    logic              seq_err;

    int               cycleCnt = 0;
    int               checks = 0;
    int               errors = 0;
    int               staCount = 0;
    expT              expQ[$];
    logic [ACT_W-1:0] lastAct = '0;
    logic [WEI_W-1:0] expWei;

    pec_row_seq #(
        .DATA_WIDTH   (DW),
        .CHANNEL_DEPTH(CD),
        .BLOCK_DEPTH  (BD),
        .KERNEL_SIZE  (KS),
        .LENPSUM      (LP),
        .TIMEOUT      (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .row_sta            (row_sta),
        .row_busy           (row_busy),
        .row_fnh            (row_fnh),
        .wei_vld            (wei_vld),
        .wei_rdy            (wei_rdy),
        .wei_flg0           (wei_flg0),
        .wei_flg1           (wei_flg1),
        .wei_flg2           (wei_flg2),
        .wei_dat            (wei_dat),
        .act_vld            (act_vld),
        .act_rdy            (act_rdy),
        .act_flg            (act_flg),
        .act_dat            (act_dat),
        .PECMAC_Sta         (PECMAC_Sta),
        .MACPEC_Fnh0        (MACPEC_Fnh0),
        .MACPEC_Fnh1        (MACPEC_Fnh1),
        .MACPEC_Fnh2        (MACPEC_Fnh2),
        .PECMAC_FlgAct      (PECMAC_FlgAct),
        .PECMAC_Act         (PECMAC_Act),
        .PECMAC_FlgWei0     (PECMAC_FlgWei0),
        .PECMAC_FlgWei1     (PECMAC_FlgWei1),
        .PECMAC_FlgWei2     (PECMAC_FlgWei2),
        .PECMAC_Wei         (PECMAC_Wei),
        .PECMAC_AddrBaseWei0(PECMAC_AddrBaseWei0),
        .PECMAC_AddrBaseWei1(PECMAC_AddrBaseWei1),
        .PECMAC_AddrBaseWei2(PECMAC_AddrBaseWei2),
        .PECCNV_PlsAcc      (PECCNV_PlsAcc),
        .PECCNV_FnhRow      (PECCNV_FnhRow),
        .seq_err            (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [ACT_W-1:0] actual,
                               input logic [ACT_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic scoreEvent(input int kind);
        expT e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedEvent: got kind %0d at cycle %0d, expected no event", kind, cycleCnt);
        end else begin
            e = expQ.pop_front();
            checkOutput("eventKind", ACT_W'(kind), ACT_W'(e.kind));
            checkOutput("eventCycle", ACT_W'(cycleCnt), ACT_W'(e.cyc));
            if (kind == KIND_STA && e.kind == KIND_STA) begin
                checkOutput("macAct", PECMAC_Act, e.act);
                checkOutput("macFlgAct", ACT_W'(PECMAC_FlgAct), ACT_W'(e.flg));
            end
            if (kind == KIND_ROW) begin
                checkOutput("rowFnhPulse", ACT_W'(row_fnh), 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (PECMAC_Sta) begin
                staCount++;
                scoreEvent(KIND_STA);
            end
            if (PECCNV_PlsAcc) scoreEvent(KIND_ACC);
            if (PECCNV_FnhRow) scoreEvent(KIND_ROW);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACT_W-1:0] makeAct(input int n);
        logic [ACT_W-1:0] v;
        for (int i = 0; i < CD; i++) v[i*DW +: DW] = 8'(n * 16 + i + 1);
        return v;
    endfunction

    function automatic logic [WEI_W-1:0] makeWei(input int seed);
        logic [WEI_W-1:0] v;
        for (int i = 0; i < BD * KS; i++) v[i*DW +: DW] = 8'(i * 7 + seed);
        return v;
    endfunction

    task automatic startRow();
        row_sta = 1'b1;
        tick();
        row_sta = 1'b0;
        @(negedge clk);
        checkOutput("wloadBusy", ACT_W'(row_busy), 1);
        checkOutput("wloadWeiRdy", ACT_W'(wei_rdy), 1);
    endtask

    task automatic loadWeights(input logic [CD-1:0] f0, input logic [CD-1:0] f1, input logic [CD-1:0] f2,
                               input int seed, input int eb1, input int eb2);
        bit ok;
        ok = 1'b0;
        wei_flg0 = f0;
        wei_flg1 = f1;
        wei_flg2 = f2;
        wei_dat  = makeWei(seed);
        expWei   = makeWei(seed);
        wei_vld  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (wei_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("weiHandshake", ACT_W'(ok), 1);
        tick();
        wei_vld = 1'b0;
        @(negedge clk);
        checkOutput("base0", ACT_W'(PECMAC_AddrBaseWei0), 0);
        checkOutput("base1", ACT_W'(PECMAC_AddrBaseWei1), ACT_W'(eb1));
        checkOutput("base2", ACT_W'(PECMAC_AddrBaseWei2), ACT_W'(eb2));
        checkOutput("flgWei0", ACT_W'(PECMAC_FlgWei0), ACT_W'(f0));
        checkOutput("flgWei1", ACT_W'(PECMAC_FlgWei1), ACT_W'(f1));
        checkOutput("flgWei2", ACT_W'(PECMAC_FlgWei2), ACT_W'(f2));
        checkOutput("weiData", ACT_W'(PECMAC_Wei == expWei), 1);
        checkOutput("aloadActRdy", ACT_W'(act_rdy), 1);
        checkOutput("aloadWeiRdy", ACT_W'(wei_rdy), 0);
        tick();
    endtask

    task automatic handshakeAct(input logic [ACT_W-1:0] d, input logic [CD-1:0] f,
                                output int s, output bit ok);
        expT e;
        act_dat = d;
        act_flg = f;
        act_vld = 1'b1;
        ok = 1'b0;
        s = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (act_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL actHandshake: got no act_rdy within 40 cycles, expected act_rdy=1");
            act_vld = 1'b0;
        end else begin
            s = cycleCnt + 1;
            e = '{KIND_STA, s, d, f};
            expQ.push_back(e);
            lastAct = d;
        end
    endtask

    // Delays are Fnh offsets from the Sta cycle (>=1); startMask is driven during START only.
    task automatic applyStimulus(input logic [ACT_W-1:0] d, input logic [CD-1:0] f,
                                 input int d0, input int d1, input int d2,
                                 input logic [2:0] startMask, input bit lastCol);
        int  s;
        int  maxd;
        bit  ok;
        expT e;
        handshakeAct(d, f, s, ok);
        if (!ok) return;
        maxd = d0;
        if (d1 > maxd) maxd = d1;
        if (d2 > maxd) maxd = d2;
        e = '{KIND_ACC, s + maxd + 1, '0, '0};
        expQ.push_back(e);
        if (lastCol) begin
            e = '{KIND_ROW, s + maxd + 2, '0, '0};
            expQ.push_back(e);
        end
        for (int k = 0; k <= maxd; k++) begin
            tick();
            act_vld = 1'b0;
            if (k == 0) begin
                {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0} = startMask;
            end else begin
                MACPEC_Fnh0 = (d0 == k);
                MACPEC_Fnh1 = (d1 == k);
                MACPEC_Fnh2 = (d2 == k);
            end
        end
        tick();
        {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0} = 3'b000;
        tick();
    endtask

    task automatic rowEnd(input int eb1, input int eb2, input int staBase);
        tick();
        @(negedge clk);
        checkOutput("idleBusy", ACT_W'(row_busy), 0);
        checkOutput("idleActRdy", ACT_W'(act_rdy), 0);
        checkOutput("rowBase1Held", ACT_W'(PECMAC_AddrBaseWei1), ACT_W'(eb1));
        checkOutput("rowBase2Held", ACT_W'(PECMAC_AddrBaseWei2), ACT_W'(eb2));
        checkOutput("staPerRow", ACT_W'(staCount - staBase), ACT_W'(LP));
        tick();
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL globalTimeout: got no finish by 300000 ns, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int  s;
        int  staBase;
        bit  ok;
        expT e;

        rst_n = 1'b0;
        row_sta = 1'b0;
        wei_vld = 1'b0;
        wei_flg0 = '0;
        wei_flg1 = '0;
        wei_flg2 = '0;
        wei_dat = '0;
        act_vld = 1'b0;
        act_flg = '0;
        act_dat = '0;
        {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0} = 3'b000;

        repeat (2) @(negedge clk);
        checkOutput("rstBusy", ACT_W'(row_busy), 0);
        checkOutput("rstStrobes", ACT_W'({PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow, row_fnh}), 0);
        checkOutput("rstRdy", ACT_W'({wei_rdy, act_rdy}), 0);
        checkOutput("rstBases", ACT_W'({PECMAC_AddrBaseWei1, PECMAC_AddrBaseWei2}), 0);
        checkOutput("rstAct", PECMAC_Act, '0);
        checkOutput("rstSeqErr", ACT_W'(seq_err), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] row 1: weight bases and back-to-back columns");
        staBase = staCount;
        startRow();
        loadWeights(32'h0000_00FF, 32'h0000_000F, 32'h0, 3, 8, 12);
        for (int c = 0; c < LP; c++) begin
            applyStimulus(makeAct(c), 32'h1111_1111 << c, 1, 1, 1, 3'b000, c == LP - 1);
        end
        rowEnd(8, 12, staBase);

        $display("[TB] row 2: backpressure, staggered finishes, finishes during START");
        staBase = staCount;
        startRow();
        loadWeights(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_00F0, 9, 32, 33);
        for (int k = 0; k < 6; k++) begin
            row_sta  = (k % 2 == 0);
            wei_vld  = 1'b1;
            wei_flg0 = 32'h0;
            @(negedge clk);
            checkOutput("bpActRdy", ACT_W'(act_rdy), 1);
            checkOutput("bpNoSta", ACT_W'(PECMAC_Sta), 0);
            checkOutput("bpWeiRdy", ACT_W'(wei_rdy), 0);
            checkOutput("bpActHeld", PECMAC_Act, lastAct);
            checkOutput("bpBase1Held", ACT_W'(PECMAC_AddrBaseWei1), 32);
            tick();
        end
        row_sta = 1'b0;
        wei_vld = 1'b0;
        applyStimulus(makeAct(4), 32'hA5A5_5A5A, 5, 9, 2, 3'b111, 1'b0);
        applyStimulus(makeAct(5), 32'h0F0F_0F0F, 1, 3, 2, 3'b000, 1'b0);
        applyStimulus(makeAct(6), 32'hF0F0_F0F0, 2, 1, 1, 3'b010, 1'b0);
        applyStimulus(makeAct(7), 32'h8000_0001, 1, 1, 1, 3'b000, 1'b1);
        rowEnd(32, 33, staBase);

        $display("[TB] row 3: reset in WAIT of column 2, then full row");
        startRow();
        loadWeights(32'h0000_00FF, 32'h0000_000F, 32'h0, 5, 8, 12);
        applyStimulus(makeAct(8), 32'h0000_0003, 1, 1, 1, 3'b000, 1'b0);
        applyStimulus(makeAct(9), 32'h0000_000C, 1, 1, 1, 3'b000, 1'b0);
        handshakeAct(makeAct(10), 32'h0000_0030, s, ok);
        tick();
        act_vld = 1'b0;
        tick();
        MACPEC_Fnh0 = 1'b1;
        tick();
        MACPEC_Fnh0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", ACT_W'(row_busy), 0);
        checkOutput("midRstStrobes", ACT_W'({PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow, row_fnh}), 0);
        checkOutput("midRstRdy", ACT_W'({wei_rdy, act_rdy}), 0);
        checkOutput("midRstBases", ACT_W'({PECMAC_AddrBaseWei1, PECMAC_AddrBaseWei2}), 0);
        checkOutput("midRstAct", PECMAC_Act, '0);
        checkOutput("midRstWei", ACT_W'(|PECMAC_Wei), 0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstHoldBusy", ACT_W'(row_busy), 0);
        end
        rst_n = 1'b1;
        tick();
        staBase = staCount;
        startRow();
        loadWeights(32'h0000_00FF, 32'h0000_000F, 32'h0, 6, 8, 12);
        for (int c = 0; c < LP; c++) begin
            applyStimulus(makeAct(11 + c), 32'h0000_0101 << c, 1, 2, 1, 3'b000, c == LP - 1);
        end
        rowEnd(8, 12, staBase);

        $display("[TB] row 4: MAC 1 never finishes");
        startRow();
        loadWeights(32'hFFFF_0000, 32'h0000_0003, 32'h0, 7, 16, 18);
        handshakeAct(makeAct(15), 32'h1234_5678, s, ok);
`ifdef PEC_ROW_WDOG_EN
        e = '{KIND_ACC, s + TO + 1, '0, '0};
        expQ.push_back(e);
`endif
        tick();
        act_vld = 1'b0;
        tick();
        MACPEC_Fnh0 = 1'b1;
        MACPEC_Fnh2 = 1'b1;
        tick();
        MACPEC_Fnh0 = 1'b0;
        MACPEC_Fnh2 = 1'b0;
`ifdef PEC_ROW_WDOG_EN
        while (cycleCnt < s + TO) tick();
        @(negedge clk);
        checkOutput("wdogErrBefore", ACT_W'(seq_err), 0);
        tick();
        @(negedge clk);
        checkOutput("wdogErrSet", ACT_W'(seq_err), 1);
        checkOutput("wdogPlsAcc", ACT_W'(PECCNV_PlsAcc), 1);
        tick();
        @(negedge clk);
        checkOutput("wdogErrSticky", ACT_W'(seq_err), 1);
        checkOutput("wdogNextCol", ACT_W'(act_rdy), 1);
`else
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checkOutput("stuckBusy", ACT_W'(row_busy), 1);
            checkOutput("stuckActRdy", ACT_W'(act_rdy), 0);
        end
        checkOutput("stuckSeqErr", ACT_W'(seq_err), 0);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("pendingEvents", ACT_W'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
